// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (I) and memory (D) stages.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise D wins every conflict.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic [DW-1:0]     i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DW/8-1:0]   d_be,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic [DW-1:0]     d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              conflict
);

    localparam int BW = DW / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    logic [1:0]    stateR;
    logic [1:0]    nextStateS;
    logic          grantIS;
    logic          grantDS;
    logic          conflictS;
    logic          doneS;
    logic          pickIS;
    logic          memReqR;
    logic          busyR;
    logic          conflictR;
    logic          memWeR;
    logic [BW-1:0] memBeR;
    logic [AW-1:0] memAddrR;
    logic [DW-1:0] memWdataR;

    assign doneS = ((stateR == GNT_I) || (stateR == GNT_D)) && mem_ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic lastServedR;

    // A conflict goes to I only when D was the last port served.
    assign pickIS = lastServedR;

    // Remember which port completed most recently; 0 = I, 1 = D.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastServedR <= 1'b0;
        end else if (doneS) begin
            lastServedR <= (stateR == GNT_D);
        end else begin
            lastServedR <= lastServedR;
        end
    end
`else
    assign pickIS = 1'b0;
`endif

    // Arbitration: from a GNT state only the other port may be granted on completion.
    always_comb begin
        nextStateS = stateR;
        grantIS    = 1'b0;
        grantDS    = 1'b0;
        conflictS  = 1'b0;
        case (stateR)
            IDLE: begin
                conflictS = i_req & d_req;
                if (i_req && d_req) begin
                    grantIS = pickIS;
                    grantDS = ~pickIS;
                end else begin
                    grantIS = i_req;
                    grantDS = d_req;
                end
                nextStateS = grantIS ? GNT_I : (grantDS ? GNT_D : IDLE);
            end
            GNT_I: begin
                if (mem_ready) begin
                    conflictS  = i_req & d_req;
                    grantDS    = d_req;
                    nextStateS = d_req ? GNT_D : IDLE;
                end else begin
                    nextStateS = GNT_I;
                end
            end
            GNT_D: begin
                if (mem_ready) begin
                    conflictS  = i_req & d_req;
                    grantIS    = i_req;
                    nextStateS = i_req ? GNT_I : IDLE;
                end else begin
                    nextStateS = GNT_D;
                end
            end
            default: begin
                nextStateS = IDLE;
            end
        endcase
    end

    // State, status flags and the captured access fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateR    <= IDLE;
            memReqR   <= 1'b0;
            busyR     <= 1'b0;
            conflictR <= 1'b0;
            memWeR    <= 1'b0;
            memBeR    <= {BW{1'b0}};
            memAddrR  <= {AW{1'b0}};
            memWdataR <= {DW{1'b0}};
        end else begin
            stateR    <= nextStateS;
            memReqR   <= (nextStateS != IDLE);
            busyR     <= (nextStateS != IDLE);
            conflictR <= conflictS;
            if (grantIS) begin
                memWeR    <= 1'b0;
                memBeR    <= {BW{1'b0}};
                memAddrR  <= i_addr;
                memWdataR <= {DW{1'b0}};
            end else if (grantDS) begin
                memWeR    <= d_we;
                memBeR    <= d_be;
                memAddrR  <= d_addr;
                memWdataR <= d_wdata;
            end else begin
                memWeR    <= memWeR;
                memBeR    <= memBeR;
                memAddrR  <= memAddrR;
                memWdataR <= memWdataR;
            end
        end
    end

    // Ready and read data pass straight through from memory during the completing cycle.
    assign i_ready   = (stateR == GNT_I) && mem_ready;
    assign d_ready   = (stateR == GNT_D) && mem_ready;
    assign i_rdata   = i_ready ? mem_rdata : {DW{1'b0}};
    assign d_rdata   = d_ready ? mem_rdata : {DW{1'b0}};

    assign mem_req   = memReqR;
    assign mem_we    = memWeR;
    assign mem_be    = memBeR;
    assign mem_addr  = memAddrR;
    assign mem_wdata = memWdataR;
    assign busy      = busyR;
    assign conflict  = conflictR;

endmodule
